// File: rtl/bw_full_adder.sv
// rtl/bw_full_adder.sv - 1-bit full adder cell for the Baugh-Wooley array
module bw_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multiplier_mxn.sv
// rtl/multiplier_mxn.sv - registered MxN modified Baugh-Wooley multiplier, signed/unsigned by P
module multiplier_mxn #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           P,
    output logic [M+N-1:0] p
);

    localparam int W = M + N;

    // When M == N the two low injections add up to a single 2^M
    localparam logic [W-1:0] INJ_A   = {{(W-1){1'b0}}, 1'b1} << (M - 1);
    localparam logic [W-1:0] INJ_B   = {{(W-1){1'b0}}, 1'b1} << (N - 1);
    localparam logic [W-1:0] INJ_TOP = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] INJ     = INJ_A + INJ_B + INJ_TOP;

    logic [N-1:0][W-1:0] rows;
    logic [N-1:0][W-1:0] s_v;
    logic [N-1:0][W-1:0] c_v;
    logic [W-1:0]        rc;
    logic [W-1:0]        p_d;
    logic [W-1:0]        p_q;

    always_comb begin
        rows = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < M; i++) begin
                rows[j][i+j] = (a[i] & b[j]) ^
                    (P & (((i == M-1) && (j < N-1)) || ((j == N-1) && (i < M-1))));
            end
        end
    end

    // Row 0 seeds the sum vector; the mode constant rides in the carry vector
    assign s_v[0] = rows[0];
    assign c_v[0] = INJ & {W{P}};

    genvar j, k;
    generate
        for (j = 1; j < N; j++) begin : g_row
            logic [W-2:0] cy;
            for (k = 0; k < W; k++) begin : g_col
                if (k == W-1) begin : g_top
                    assign s_v[j][k] = s_v[j-1][k] ^ c_v[j-1][k] ^ rows[j][k];
                end else begin : g_fa
                    bw_full_adder u_fa (
                        .a    (s_v[j-1][k]),
                        .b    (c_v[j-1][k]),
                        .cin  (rows[j][k]),
                        .s    (s_v[j][k]),
                        .cout (cy[k])
                    );
                end
            end
            assign c_v[j] = {cy, 1'b0};
        end

        assign rc[0] = 1'b0;
        for (k = 0; k < W; k++) begin : g_rca
            if (k == W-1) begin : g_top
                assign p_d[k] = s_v[N-1][k] ^ c_v[N-1][k] ^ rc[k];
            end else begin : g_fa
                bw_full_adder u_fa (
                    .a    (s_v[N-1][k]),
                    .b    (c_v[N-1][k]),
                    .cin  (rc[k]),
                    .s    (p_d[k]),
                    .cout (rc[k+1])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_multiplier_mxn.sv
// tb/tb_multiplier_mxn.sv - scoreboard bench for multiplier_mxn against an arithmetic model
module tb_multiplier_mxn;

    localparam int M = 4;
    localparam int N = 4;
    localparam int W = M + N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [M-1:0] a = 4'hA;
    logic [N-1:0] b = 4'h2;
    logic         mode = 1'b0;
    logic [W-1:0] p;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    multiplier_mxn #(.M(M), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .P     (mode),
        .p     (p)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] golden(input logic [M-1:0] x, input logic [N-1:0] y,
                                            input logic m);
        longint sx;
        longint sy;
        longint prod;
        sx = longint'(x);
        sy = longint'(y);
        if (m && x[M-1]) sx = sx - (longint'(1) << M);
        if (m && y[N-1]) sy = sy - (longint'(1) << N);
        prod = sx * sy;
        return prod[W-1:0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (a=%h b=%h P=%b)", name, got, want, a, b, mode);
        end
    endtask

    task automatic apply(input logic [M-1:0] x, input logic [N-1:0] y, input logic m,
                         input logic [W-1:0] want);
        @(negedge clk);
        a = x;
        b = y;
        mode = m;
        @(posedge clk);
        exp_q.push_back(want);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("async_clear", p, '0);
        @(posedge clk);
        #2 check("held_clear", p, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("product", p, e);
            end
        end
    end

    initial begin : driver
        logic [M-1:0] x;
        logic [N-1:0] y;
        logic         m;

        #1 check("reset_immediate", p, '0);
        repeat (2) begin
            @(posedge clk);
            #2 check("reset_held", p, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        apply(4'b1010, 4'b0010, 1'b1, 8'hF4);
        apply(4'b1010, 4'b0010, 1'b0, 8'h14);
        apply(4'b1010, 4'b0010, 1'b1, 8'hF4);
        apply(4'h8, 4'h8, 1'b1, 8'h40);
        apply(4'h8, 4'h7, 1'b1, 8'hC8);
        apply(4'hF, 4'hF, 1'b1, 8'h01);
        apply(4'hF, 4'hF, 1'b0, 8'hE1);
        apply(4'h0, 4'h9, 1'b0, 8'h00);
        apply(4'h0, 4'h9, 1'b1, 8'h00);
        apply(4'h7, 4'h7, 1'b1, 8'h31);

        for (int md = 0; md < 2; md++) begin
            for (int v = 0; v < (1 << W); v++) begin
                x = v[M-1:0];
                y = v[W-1:M];
                m = md[0];
                apply(x, y, m, golden(x, y, m));
                if (md == 0 && v == 150) pulse_reset();
            end
        end

        for (int r = 0; r < 300; r++) begin
            x = M'($urandom);
            y = N'($urandom);
            m = 1'($urandom);
            apply(x, y, m, golden(x, y, m));
            if (r == 120) pulse_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
